// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage FSM encoding, used by inst_fetch,
// pc_unit and inst_dec.
package cpu_pkg;

  localparam int CPU_AW = 16;
  localparam int CPU_DW = 16;
  localparam logic [CPU_AW-1:0] CPU_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Prefetch queue: DEPTH entries (power of two), synchronous active-low reset,
// single-cycle clear. Push and pop in the same cycle are both honoured.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  // Popping an empty queue is a no-op.
  assign do_pop = pop && (count != '0);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !clear && push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetch pointer, credit-limited RAM reads, prefetch queue.
// Optional perf counters (stall_cnt, flush_cnt) when INST_FETCH_PERF_EN is defined.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = CPU_AW,
  parameter int            DW       = CPU_DW,
  parameter logic [AW-1:0] RESET_PC = AW'(CPU_RESET_PC),
  localparam int           CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [CW-1:0] count
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt
`endif
);

  fetch_state_e     state, state_d;
  logic [AW-1:0]    pc, inflight_pc;
  logic             inflight;
  logic             push, pop;
  logic [AW+DW-1:0] head;
  logic [CW:0]      occ_next;

  assign mem_re      = (state == FETCH);
  assign mem_addr    = pc;
  assign push        = inflight;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? head[DW-1:0] : '0;
  assign instr_pc    = instr_valid ? head[AW+DW-1:DW] : '0;

  sync_fifo #(.DEPTH(DEPTH), .W(AW+DW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({inflight_pc, mem_rdata}),
    .rdata (head),
    .count (count)
  );

  // Next-cycle occupancy including the read that will be in flight; a read is
  // only allowed when this leaves room, so a returning push can never overflow.
  always_comb begin
    occ_next = (CW+1)'(count) + (CW+1)'(push) + (CW+1)'(mem_re) - (CW+1)'(pop);
    state_d  = state;
    if (redirect)                         state_d = FLUSH;
    else if (!en)                         state_d = IDLE;
    else if (occ_next >= (CW+1)'(DEPTH))  state_d = FULL;
    else                                  state_d = FETCH;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_re;
      if (mem_re) begin
        inflight_pc <= pc;
        pc          <= pc + 1'b1;
      end
    end
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (instr_ready && !instr_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && flush_cnt != 16'hFFFF)                    flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
